btn_event_encoder: RTL and testbench

//   Front end for the push-button interface: synchronises and debounces btnC/U/L/R/D.

---
 rtl/btn_event_encoder.sv | 128 ++++++++++++
 tb/tb_btn_event_encoder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/btn_event_encoder.sv
// Push-button front end: per-button sync + debounce, press-edge detection,
// priority arbitration into a show-ahead event FIFO drained on valid/ready.

module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      // counter only runs while the synchronised input disagrees with the accepted level
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CMAX) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module btn_event_encoder #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btnC,
  input  logic       btnU,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       btnD,
  output logic       ev_valid,
  output logic [2:0] ev_code,
  input  logic       ev_ready,
  output logic [4:0] btn_level,
  output logic       overflow,
  input  logic       clear_ovf
);
  localparam int NB = 5;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  logic [NB-1:0] raw;
  logic [NB-1:0] level_d, press, pending, grant, grant_eff, drop;
  logic [2:0]    push_code, head_nxt;
  logic [2:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [PW:0]   count, count_nxt;
  logic          push, pop;

  assign raw = {btnD, btnR, btnL, btnU, btnC};

  for (genvar g = 0; g < NB; g++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw[g]),
      .level (btn_level[g])
    );
  end

  assign press = btn_level & ~level_d;

  // lowest index wins: isolate the least-significant pending bit
  assign grant = pending & (~pending + 1'b1);

  always_comb begin
    push_code = 3'd0;
    for (int i = NB - 1; i >= 0; i--)
      if (pending[i]) push_code = 3'(i + 1);
  end

  assign pop       = ev_valid & ev_ready;
  assign push      = (|pending) & ((count < DEPTH_C) | pop);
  assign grant_eff = push ? grant : '0;
  assign drop      = press & pending & ~grant_eff;

  assign rd_nxt    = rd_ptr + PW'(pop);
  assign count_nxt = count + (PW+1)'(push) - (PW+1)'(pop);
  // a push into an otherwise-empty slot becomes the head directly
  assign head_nxt  = (push && rd_nxt == wr_ptr) ? push_code : mem[rd_nxt];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d  <= '0;
      pending  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      ev_valid <= 1'b0;
      ev_code  <= 3'd0;
    end else begin
      level_d  <= btn_level;
      pending  <= (pending & ~grant_eff) | press;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr   <= rd_nxt;
      count    <= count_nxt;
      if (|drop)          overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
      ev_valid <= (count_nxt != '0);
      ev_code  <= (count_nxt != '0) ? head_nxt : 3'd0;
    end
  end
endmodule

// File: tb/tb_btn_event_encoder.sv
// Directed bench for btn_event_encoder with a short debounce window.

module tb_btn_event_encoder;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] btns;
  logic       ev_valid, ev_ready, overflow, clear_ovf;
  logic [2:0] ev_code;
  logic [4:0] btn_level;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  btn_event_encoder #(.DEBOUNCE_CYCLES(8), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btnC      (btns[0]),
    .btnU      (btns[1]),
    .btnL      (btns[2]),
    .btnR      (btns[3]),
    .btnD      (btns[4]),
    .ev_valid  (ev_valid),
    .ev_code   (ev_code),
    .ev_ready  (ev_ready),
    .btn_level (btn_level),
    .overflow  (overflow),
    .clear_ovf (clear_ovf)
  );

  typedef struct {
    logic [4:0] btns;
    logic       rdy;
    int         cyc;
    logic       vld;
    logic [2:0] code;
    logic [4:0] lvl;
  } vec_t;

  vec_t vecs[$];

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic v, input logic [2:0] c);
    chk({nm, " valid"}, 32'(ev_valid), 32'(v));
    chk({nm, " code"},  32'(ev_code),  32'(c));
  endtask

  initial begin
    logic [2:0] exp4 [4];
    logic [2:0] exp6 [8];
    logic [4:0] masks [4];

    // single-button vectors: glitch, exact debounce boundary, then each button
    vecs.push_back('{5'b00100, 1'b0, 5,  1'b0, 3'd0, 5'b00000});
    vecs.push_back('{5'b00000, 1'b0, 12, 1'b0, 3'd0, 5'b00000});
    vecs.push_back('{5'b00100, 1'b0, 9,  1'b0, 3'd0, 5'b00000});
    vecs.push_back('{5'b00100, 1'b0, 1,  1'b0, 3'd0, 5'b00100});
    vecs.push_back('{5'b00100, 1'b0, 1,  1'b0, 3'd0, 5'b00100});
    vecs.push_back('{5'b00100, 1'b0, 1,  1'b1, 3'd3, 5'b00100});
    vecs.push_back('{5'b00000, 1'b1, 1,  1'b0, 3'd0, 5'b00100});
    vecs.push_back('{5'b00000, 1'b1, 11, 1'b0, 3'd0, 5'b00000});
    masks = '{5'b00001, 5'b00010, 5'b01000, 5'b10000};
    exp4  = '{3'd1, 3'd2, 3'd4, 3'd5};
    for (int i = 0; i < 4; i++) begin
      vecs.push_back('{masks[i], 1'b0, 12, 1'b1, exp4[i], masks[i]});
      vecs.push_back('{5'b00000, 1'b1, 1,  1'b0, 3'd0,    masks[i]});
      vecs.push_back('{5'b00000, 1'b1, 11, 1'b0, 3'd0,    5'b00000});
    end

    rst_n = 1'b0; btns = '0; ev_ready = 1'b0; clear_ovf = 1'b0;
    step(3);
    chk_out("reset", 1'b0, 3'd0);
    chk("reset level", 32'(btn_level), 32'd0);
    chk("reset ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    step(2);

    for (int i = 0; i < vecs.size(); i++) begin
      btns = vecs[i].btns; ev_ready = vecs[i].rdy;
      step(vecs[i].cyc);
      chk_out($sformatf("vec%0d", i), vecs[i].vld, vecs[i].code);
      chk($sformatf("vec%0d level", i), 32'(btn_level), 32'(vecs[i].lvl));
      chk($sformatf("vec%0d ovf", i), 32'(overflow), 32'd0);
    end

    // simultaneous C+D with ready held: C first, D next cycle
    ev_ready = 1'b1; btns = 5'b10001;
    step(12); chk_out("simul first", 1'b1, 3'd1);
    step(1);  chk_out("simul second", 1'b1, 3'd5);
    step(1);  chk_out("simul drained", 1'b0, 3'd0);
    btns = '0; step(12);

    // backpressure: U,L,R,D fill the FIFO, C waits pending
    ev_ready = 1'b0;
    masks = '{5'b00010, 5'b00100, 5'b01000, 5'b10000};
    for (int i = 0; i < 4; i++) begin
      btns = btns | masks[i]; step(12);
    end
    btns = btns | 5'b00001; step(12);
    chk_out("bp full head", 1'b1, 3'd2);
    chk("bp ovf", 32'(overflow), 32'd0);
    btns = '0; step(12);
    chk_out("bp after release", 1'b1, 3'd2);
    ev_ready = 1'b1;
    exp4 = '{3'd3, 3'd4, 3'd5, 3'd1};
    for (int i = 0; i < 4; i++) begin
      step(1); chk_out($sformatf("bp drain%0d", i), 1'b1, exp4[i]);
    end
    step(1); chk_out("bp empty", 1'b0, 3'd0);

    // overflow: full FIFO, U pending, U pressed again
    ev_ready = 1'b0;
    btns = 5'b11101; step(15);
    btns = 5'b11111; step(12);
    chk("ovf none yet", 32'(overflow), 32'd0);
    chk_out("ovf head", 1'b1, 3'd1);
    btns = 5'b11101; step(12);
    btns = 5'b11111; step(12);
    chk("ovf set", 32'(overflow), 32'd1);
    clear_ovf = 1'b1; step(1); clear_ovf = 1'b0;
    chk("ovf cleared", 32'(overflow), 32'd0);
    btns = 5'b11101; step(12);
    btns = 5'b11111; step(10);
    clear_ovf = 1'b1; step(1); clear_ovf = 1'b0;
    chk("ovf set beats clear", 32'(overflow), 32'd1);
    step(1);
    chk("ovf sticky", 32'(overflow), 32'd1);

    // throughput: full FIFO plus all five pending, push+pop every cycle
    clear_ovf = 1'b1; step(1); clear_ovf = 1'b0;
    btns = 5'b00010; step(12);
    btns = 5'b11111; step(12);
    chk("tp ovf", 32'(overflow), 32'd0);
    chk_out("tp head", 1'b1, 3'd1);
    ev_ready = 1'b1;
    exp6 = '{3'd3, 3'd4, 3'd5, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    for (int i = 0; i < 8; i++) begin
      step(1); chk_out($sformatf("tp%0d", i), 1'b1, exp6[i]);
    end
    step(1); chk_out("tp empty", 1'b0, 3'd0);
    ev_ready = 1'b0; btns = '0; step(12);

    // reset mid-stream with three queued events
    btns = 5'b00111; step(14);
    chk_out("pre-reset", 1'b1, 3'd1);
    rst_n = 1'b0; btns = '0; #1;
    chk_out("async reset", 1'b0, 3'd0);
    chk("async reset level", 32'(btn_level), 32'd0);
    chk("async reset ovf", 32'(overflow), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(20);
    chk_out("post reset", 1'b0, 3'd0);
    chk("post reset level", 32'(btn_level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
